// File: rtl/anim_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : anim_sequencer
// Description : Steps through the frames of a selected animation at a
//               programmable frame period, committing each new frame only
//               during display vertical blanking. Supports pause, stop,
//               finite or infinite looping.
//               Optional macro ANIM_PINGPONG_EN adds a 'pingpong' input that
//               plays 0..N-1..0 instead of wrapping forward.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_sequencer #(
    parameter int NUM_ANIMS  = 4,
    parameter int MAX_FRAMES = 8,
    parameter int ANIM_W     = 2,
    parameter int FRAME_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [ANIM_W-1:0]  anim_sel,
    input  logic [FRAME_W:0]   num_frames,
    input  logic [31:0]        speed,
    input  logic [7:0]         loops,
`ifdef ANIM_PINGPONG_EN
    input  logic               pingpong,
`endif
    input  logic               vblank,
    output logic [ANIM_W-1:0]  anim_actual,
    output logic [FRAME_W-1:0] frame_actual,
    output logic               frame_changed,
    output logic               done,
    output logic               busy
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_PAUSED  = 2'd2;
    localparam logic [1:0] c_WAIT_VB = 2'd3;

    localparam logic [FRAME_W:0] c_NF_ONE = (FRAME_W+1)'(1);
    localparam logic [FRAME_W:0] c_MAX_NF = (FRAME_W+1)'(MAX_FRAMES);

    // Animation index must be able to address every animation.
    if (NUM_ANIMS > (1 << ANIM_W)) begin : g_bad_anim_w
        $error("ANIM_W too narrow for NUM_ANIMS");
    end

    logic [1:0]         r_state;
    logic [ANIM_W-1:0]  r_anim;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] r_pending;
    logic               r_fc;
    logic               r_done;
    logic [31:0]        r_cnt;
    logic [7:0]         r_loop_cnt;
    logic [31:0]        r_speed;
    logic [FRAME_W:0]   r_nf;
    logic [7:0]         r_loops;

    logic [31:0]        w_speed_eff;
    logic [FRAME_W:0]   w_nf_eff;
    logic [FRAME_W-1:0] w_pend;
    logic               w_last;
    logic               w_term;
    logic               w_final;

`ifdef ANIM_PINGPONG_EN
    logic               r_pp;
    logic               r_dir_down;
    logic               r_pend_down;
    logic               w_pend_down;
`endif

    assign w_speed_eff = (speed == 32'd0) ? 32'd1 : speed;
    assign w_last      = ({1'b0, r_frame} == (r_nf - c_NF_ONE));
    assign w_term      = (r_cnt == (r_speed - 32'd1));
    // Arrival at frame 0 closes a loop; the last permitted loop ends the run.
    assign w_final     = (r_pending == '0) && (r_loops != 8'd0) &&
                         ((r_loop_cnt + 8'd1) == r_loops);

    // Clamp the requested frame count into 1..MAX_FRAMES.
    always_comb begin
        w_nf_eff = num_frames;
        if (num_frames == '0) begin
            w_nf_eff = c_NF_ONE;
        end else if (num_frames > c_MAX_NF) begin
            w_nf_eff = c_MAX_NF;
        end
    end

    // Next frame to show once the current period expires.
    always_comb begin
        w_pend = '0;
        if (!w_last) begin
            w_pend = r_frame + 1'b1;
        end
`ifdef ANIM_PINGPONG_EN
        w_pend_down = 1'b0;
        if (r_pp) begin
            if (r_dir_down) begin
                w_pend      = r_frame - 1'b1;
                w_pend_down = 1'b1;
            end else if (w_last) begin
                w_pend      = (r_nf == c_NF_ONE) ? '0 : r_frame - 1'b1;
                w_pend_down = 1'b1;
            end
            if (w_pend == '0) begin
                w_pend_down = 1'b0;
            end
        end
`endif
    end

    // Sequencer state, frame timing and vblank-aligned frame commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_anim     <= '0;
            r_frame    <= '0;
            r_pending  <= '0;
            r_fc       <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_loop_cnt <= '0;
            r_speed    <= '0;
            r_nf       <= '0;
            r_loops    <= '0;
`ifdef ANIM_PINGPONG_EN
            r_pp        <= 1'b0;
            r_dir_down  <= 1'b0;
            r_pend_down <= 1'b0;
`endif
        end else begin
            r_fc   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !stop) begin
                        r_state    <= c_RUN;
                        r_anim     <= anim_sel;
                        r_frame    <= '0;
                        r_fc       <= 1'b1;
                        r_cnt      <= '0;
                        r_loop_cnt <= '0;
                        r_speed    <= w_speed_eff;
                        r_nf       <= w_nf_eff;
                        r_loops    <= loops;
`ifdef ANIM_PINGPONG_EN
                        r_pp       <= pingpong;
                        r_dir_down <= 1'b0;
`endif
                    end
                end
                c_RUN: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else if (pause) begin
                        r_state <= c_PAUSED;
                    end else if (w_term) begin
                        r_cnt     <= '0;
                        r_pending <= w_pend;
                        r_state   <= c_WAIT_VB;
`ifdef ANIM_PINGPONG_EN
                        r_pend_down <= w_pend_down;
`endif
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_PAUSED: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else if (!pause) begin
                        r_state <= c_RUN;
                    end
                end
                c_WAIT_VB: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else if (vblank) begin
                        if (w_final) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_frame <= r_pending;
                            r_fc    <= 1'b1;
                            r_state <= c_RUN;
                            if (r_pending == '0) begin
                                r_loop_cnt <= r_loop_cnt + 8'd1;
                            end
`ifdef ANIM_PINGPONG_EN
                            r_dir_down <= r_pend_down;
`endif
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign anim_actual   = r_anim;
    assign frame_actual  = r_frame;
    assign frame_changed = r_fc;
    assign done          = r_done;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire
